// File: rtl/alu_sequencer.sv
// ---------------------------------------------------------------------------
// alu_sequencer
//
// Purpose:
//   Hardwired control sequencer for a single-bus ALU datapath. Fetches an
//   instruction (T0-T2), decodes it (T3) and runs it through the ALU
//   (T4-T6), issuing the datapath strobes and one-hot register selects.
//   Retired instructions are counted; illegal opcodes and memory timeouts
//   raise a sticky Fault and return the sequencer to IDLE.
//
// Parameters:
//   NUM_REGS    number of general registers (power of 2, 2..32)
//   MEM_TIMEOUT maximum T1 cycles spent waiting for Mem_Ready
//   CNT_W       width of Instr_Count
//
// Ports:
//   Clock        in   system clock, rising edge
//   Clear        in   asynchronous active-low reset
//   Run, Stop    in   level start / halt requests
//   IR[31:0]     in   instruction register contents
//   Mem_Ready    in   memory read data valid
//   PC_Out .. Read  out  datapath strobes (registered)
//   CONTROL[4:0] out  ALU operation code (opcode in T4..T6, else 0)
//   Reg_Out      out  one-hot register bus-drive select
//   Reg_In       out  one-hot register load select
//   Busy         out  high in every state except IDLE
//   Fault        out  sticky fault flag, cleared only by reset
//   Instr_Count  out  saturating count of retired instructions
// ---------------------------------------------------------------------------
module alu_sequencer #(
  parameter int NUM_REGS    = 16,
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic                Clock,
  input  logic                Clear,
  input  logic                Run,
  input  logic                Stop,
  input  logic [31:0]         IR,
  input  logic                Mem_Ready,
  output logic                PC_Out,
  output logic                MDR_Out,
  output logic                ZLO_Out,
  output logic                ZHI_Out,
  output logic                PC_In,
  output logic                MDR_In,
  output logic                MAR_In,
  output logic                IR_In,
  output logic                Y_In,
  output logic                ZLO_In,
  output logic                ZHI_In,
  output logic                IncPC,
  output logic                Read,
  output logic [4:0]          CONTROL,
  output logic [NUM_REGS-1:0] Reg_Out,
  output logic [NUM_REGS-1:0] Reg_In,
  output logic                Busy,
  output logic                Fault,
  output logic [CNT_W-1:0]    Instr_Count
);

  localparam int IW = $clog2(NUM_REGS);
  localparam int WW = $clog2(MEM_TIMEOUT + 1);

  typedef logic [IW-1:0]       idx_t;
  typedef logic [NUM_REGS-1:0] reg_vec_t;

  localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);
  localparam reg_vec_t      REG_ONE   = reg_vec_t'(1);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  state_t        state;
  state_t        state_nxt;
  logic          started;
  logic [WW-1:0] wait_cnt;

  logic [4:0] opcode;
  idx_t       ra_idx;
  idx_t       rb_idx;
  idx_t       rc_idx;
  idx_t       ra_wrap;
  logic       is_wide;
  logic       is_unary;
  logic       is_legal;
  logic       run_ok;
  logic       retire;
  logic       mem_timeout;
  logic       fault_evt;
  logic       unused_ir;

  // Field decode; the size casts reduce each 4-bit field modulo NUM_REGS.
  assign opcode    = IR[31:27];
  assign ra_idx    = idx_t'(IR[26:23]);
  assign rb_idx    = idx_t'(IR[22:19]);
  assign rc_idx    = idx_t'(IR[18:15]);
  assign ra_wrap   = ra_idx + idx_t'(1);
  assign unused_ir = ^IR[14:0];

  assign is_wide  = (opcode == 5'h0E) || (opcode == 5'h0F);
  assign is_unary = (opcode == 5'h10) || (opcode == 5'h11);
  assign is_legal = (opcode <= 5'h0D) || is_wide || is_unary;

  assign run_ok      = Run && !Stop;
  assign retire      = ((state == T5) && !is_wide) || (state == T6);
  assign mem_timeout = (state == T1) && !Mem_Ready && (wait_cnt == WAIT_LAST);
  assign fault_evt   = mem_timeout || ((state == T3) && !is_legal);

  // Next-state decision. Stop is only looked at on the retire cycle so an
  // instruction in flight always completes.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (started && run_ok) state_nxt = T0;
      T0:   state_nxt = T1;
      T1: begin
        if (Mem_Ready)        state_nxt = T2;
        else if (mem_timeout) state_nxt = IDLE;
        else                  state_nxt = T1;
      end
      T2:   state_nxt = T3;
      T3:   state_nxt = is_legal ? T4 : IDLE;
      T4:   state_nxt = T5;
      T5: begin
        if (is_wide)     state_nxt = T6;
        else if (run_ok) state_nxt = T0;
        else             state_nxt = IDLE;
      end
      T6:   state_nxt = run_ok ? T0 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, status and strobe registers. Strobes are computed from the state
  // being entered so each one is a clean flop output for that whole state.
  // started holds off the first fetch until the second edge after reset.
  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state       <= IDLE;
      started     <= 1'b0;
      wait_cnt    <= '0;
      Fault       <= 1'b0;
      Instr_Count <= '0;
      PC_Out      <= 1'b0;
      MDR_Out     <= 1'b0;
      ZLO_Out     <= 1'b0;
      ZHI_Out     <= 1'b0;
      PC_In       <= 1'b0;
      MDR_In      <= 1'b0;
      MAR_In      <= 1'b0;
      IR_In       <= 1'b0;
      Y_In        <= 1'b0;
      ZLO_In      <= 1'b0;
      ZHI_In      <= 1'b0;
      IncPC       <= 1'b0;
      Read        <= 1'b0;
      Busy        <= 1'b0;
    end else begin
      state   <= state_nxt;
      started <= 1'b1;

      if (state != T1)     wait_cnt <= '0;
      else if (!Mem_Ready) wait_cnt <= wait_cnt + WW'(1);

      if (fault_evt) Fault <= 1'b1;

      if (retire && (Instr_Count != '1)) Instr_Count <= Instr_Count + CNT_W'(1);

      PC_Out  <= (state_nxt == T0);
      MAR_In  <= (state_nxt == T0);
      IncPC   <= (state_nxt == T0);
      ZLO_In  <= (state_nxt == T0) || (state_nxt == T4);
      ZLO_Out <= (state_nxt == T1) || (state_nxt == T5);
      Read    <= (state_nxt == T1);
      MDR_In  <= (state_nxt == T1);
      PC_In   <= (state_nxt == T1) && (state != T1);
      MDR_Out <= (state_nxt == T2);
      IR_In   <= (state_nxt == T2);
      Y_In    <= (state_nxt == T3);
      ZHI_In  <= (state_nxt == T4) && is_wide;
      ZHI_Out <= (state_nxt == T6);
      Busy    <= (state_nxt != IDLE);
    end
  end

  // Register selects and CONTROL depend on IR, which the datapath only loads
  // at the end of T2, so they are decoded from the registered state and the
  // current IR rather than precomputed a cycle early.
  always_comb begin
    CONTROL = 5'b00000;
    Reg_Out = '0;
    Reg_In  = '0;
    case (state)
      T3: Reg_Out = REG_ONE << rb_idx;
      T4: begin
        CONTROL = opcode;
        if (!is_unary) Reg_Out = REG_ONE << rc_idx;
      end
      T5: begin
        CONTROL = opcode;
        Reg_In  = REG_ONE << ra_idx;
      end
      T6: begin
        CONTROL = opcode;
        Reg_In  = REG_ONE << ra_wrap;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_sequencer
//
// Purpose:
//   Self-checking bench for alu_sequencer. Each instruction is expanded into
//   the list of phases it should visit (T0, T1 x wait, T2, T3, ...) and every
//   cycle's outputs are compared with a vector built from the per-phase
//   strobe table. Directed cases cover reset, the documented examples,
//   memory wait/timeout, illegal opcodes, Stop and mid-instruction Clear;
//   a randomized run follows.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_alu_sequencer;

  localparam int NREG    = 16;
  localparam int TIMEOUT = 8;
  localparam int CW      = 4;
  localparam int MAXCNT  = (1 << CW) - 1;

  // Strobe bit positions inside the packed comparison vector
  localparam int B_PCOUT  = 12;
  localparam int B_MDROUT = 11;
  localparam int B_ZLOOUT = 10;
  localparam int B_ZHIOUT = 9;
  localparam int B_PCIN   = 8;
  localparam int B_MDRIN  = 7;
  localparam int B_MARIN  = 6;
  localparam int B_IRIN   = 5;
  localparam int B_YIN    = 4;
  localparam int B_ZLOIN  = 3;
  localparam int B_ZHIIN  = 2;
  localparam int B_INCPC  = 1;
  localparam int B_READ   = 0;

  logic            Clock = 1'b0;
  logic            Clear;
  logic            Run;
  logic            Stop;
  logic [31:0]     IR;
  logic            Mem_Ready;
  logic            PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In;
  logic            IR_In, Y_In, ZLO_In, ZHI_In, IncPC, Read;
  logic [4:0]      CONTROL;
  logic [NREG-1:0] Reg_Out;
  logic [NREG-1:0] Reg_In;
  logic            Busy;
  logic            Fault;
  logic [CW-1:0]   Instr_Count;

  int total = 0;
  int bad   = 0;
  int expCount;
  bit expFault;

  logic [63:0] obsVec;

  alu_sequencer #(
    .NUM_REGS   (NREG),
    .MEM_TIMEOUT(TIMEOUT),
    .CNT_W      (CW)
  ) dut (
    .Clock      (Clock),
    .Clear      (Clear),
    .Run        (Run),
    .Stop       (Stop),
    .IR         (IR),
    .Mem_Ready  (Mem_Ready),
    .PC_Out     (PC_Out),
    .MDR_Out    (MDR_Out),
    .ZLO_Out    (ZLO_Out),
    .ZHI_Out    (ZHI_Out),
    .PC_In      (PC_In),
    .MDR_In     (MDR_In),
    .MAR_In     (MAR_In),
    .IR_In      (IR_In),
    .Y_In       (Y_In),
    .ZLO_In     (ZLO_In),
    .ZHI_In     (ZHI_In),
    .IncPC      (IncPC),
    .Read       (Read),
    .CONTROL    (CONTROL),
    .Reg_Out    (Reg_Out),
    .Reg_In     (Reg_In),
    .Busy       (Busy),
    .Fault      (Fault),
    .Instr_Count(Instr_Count)
  );

  always #5 Clock = ~Clock;

  assign obsVec = {13'b0, PC_Out, MDR_Out, ZLO_Out, ZHI_Out, PC_In, MDR_In, MAR_In,
                   IR_In, Y_In, ZLO_In, ZHI_In, IncPC, Read, CONTROL, Reg_Out, Reg_In, Busy};

  // Instruction classes: 0 binary, 1 64-bit, 2 unary, 3 illegal
  function automatic int opClass(input logic [4:0] op);
    if (op <= 5'h0D) return 0;
    if (op == 5'h0E || op == 5'h0F) return 1;
    if (op == 5'h10 || op == 5'h11) return 2;
    return 3;
  endfunction

  function automatic logic [31:0] mkIr(input logic [4:0] op, input int ra, input int rb, input int rc);
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    a = 4'(ra);
    b = 4'(rb);
    c = 4'(rc);
    return {op, a, b, c, 15'b0};
  endfunction

  // Expected outputs for one cycle in a given phase (-1 = IDLE)
  function automatic logic [63:0] phaseVec(input int phase, input logic [31:0] ir, input bit firstT1);
    logic [12:0]     s;
    logic [4:0]      ctl;
    logic [NREG-1:0] ro;
    logic [NREG-1:0] ri;
    int op, ra, rb, rc, cls;
    s   = '0;
    ctl = '0;
    ro  = '0;
    ri  = '0;
    op  = int'(ir[31:27]);
    ra  = int'(ir[26:23]) % NREG;
    rb  = int'(ir[22:19]) % NREG;
    rc  = int'(ir[18:15]) % NREG;
    cls = opClass(ir[31:27]);
    if (phase < 0) return 64'd0;
    case (phase)
      0: begin
        s[B_PCOUT] = 1'b1; s[B_MARIN] = 1'b1; s[B_INCPC] = 1'b1; s[B_ZLOIN] = 1'b1;
      end
      1: begin
        s[B_ZLOOUT] = 1'b1; s[B_READ] = 1'b1; s[B_MDRIN] = 1'b1;
        if (firstT1) s[B_PCIN] = 1'b1;
      end
      2: begin
        s[B_MDROUT] = 1'b1; s[B_IRIN] = 1'b1;
      end
      3: begin
        s[B_YIN] = 1'b1; ro[rb] = 1'b1;
      end
      4: begin
        s[B_ZLOIN] = 1'b1; ctl = 5'(op);
        if (cls != 2) ro[rc] = 1'b1;
        if (cls == 1) s[B_ZHIIN] = 1'b1;
      end
      5: begin
        s[B_ZLOOUT] = 1'b1; ctl = 5'(op); ri[ra] = 1'b1;
      end
      default: begin
        s[B_ZHIOUT] = 1'b1; ctl = 5'(op); ri[(ra + 1) % NREG] = 1'b1;
      end
    endcase
    return {13'b0, s, ctl, ro, ri, 1'b1};
  endfunction

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  task automatic checkStatus(input string tag);
    checkOutput({tag, "_fault"}, {63'b0, Fault}, {63'b0, expFault});
    checkOutput({tag, "_count"}, {{(64-CW){1'b0}}, Instr_Count}, 64'(expCount));
  endtask

  // Observe one IDLE cycle, then request the next instruction
  task automatic checkIdle(input string tag);
    @(negedge Clock);
    checkOutput({tag, "_idle"}, obsVec, phaseVec(-1, 32'b0, 1'b0));
    checkStatus({tag, "_idle"});
    Run  = 1'b1;
    Stop = 1'b0;
  endtask

  // Reset, then release Clear with Run high: the first edge afterwards must
  // still leave the sequencer idle, the second one starts T0.
  task automatic resetDut();
    @(negedge Clock);
    Clear     = 1'b0;
    Run       = 1'b1;
    Stop      = 1'b0;
    Mem_Ready = 1'b0;
    #1;
    expFault = 1'b0;
    expCount = 0;
    checkOutput("reset_outputs", obsVec, 64'd0);
    checkStatus("reset");
    @(negedge Clock);
    Clear = 1'b1;
    @(negedge Clock);
    checkOutput("reset_first_edge_idle", obsVec, 64'd0);
  endtask

  // Run one instruction whose T0 starts at the next rising edge.
  //   zeros      : T1 cycles with Mem_Ready low before it rises
  //   stopPhase  : phase in which Stop is raised (-1 none)
  //   runAfter   : Run level on the retire cycle
  //   abortPhase : phase in which Clear is pulsed low (-1 none)
  task automatic applyStimulus(input logic [31:0] ir, input int zeros, input int stopPhase,
                               input bit runAfter, input int abortPhase, output bit goesT0);
    int    phases[$];
    int    cls;
    int    t1Len;
    int    t1Seen;
    bit    timedOut;
    bit    stopped;
    string tg;
    cls      = opClass(ir[31:27]);
    timedOut = (zeros >= TIMEOUT);
    t1Len    = timedOut ? TIMEOUT : zeros + 1;
    phases.push_back(0);
    repeat (t1Len) phases.push_back(1);
    if (!timedOut) begin
      phases.push_back(2);
      phases.push_back(3);
      if (cls != 3) begin
        phases.push_back(4);
        phases.push_back(5);
        if (cls == 1) phases.push_back(6);
      end
    end
    t1Seen  = 0;
    stopped = 1'b0;
    goesT0  = 1'b0;
    foreach (phases[i]) begin
      @(negedge Clock);
      tg = $sformatf("ir%h_T%0d_c%0d", ir, phases[i], i);
      checkOutput(tg, obsVec, phaseVec(phases[i], ir, (phases[i] == 1) && (t1Seen == 0)));
      if (phases[i] == 0) begin
        checkStatus(tg);
        IR = ir;
      end
      if (phases[i] == 1) begin
        Mem_Ready = (t1Seen >= zeros);
        t1Seen++;
      end else begin
        Mem_Ready = 1'($urandom_range(0, 1));
      end
      if (phases[i] == abortPhase) begin
        Clear = 1'b0;
        #1;
        expFault = 1'b0;
        expCount = 0;
        checkOutput({tg, "_clear"}, obsVec, 64'd0);
        checkStatus({tg, "_clear"});
        return;
      end
      if (phases[i] == stopPhase) begin
        Stop    = 1'b1;
        stopped = 1'b1;
      end
      Run = 1'($urandom_range(0, 1));
      if (i == phases.size() - 1) begin
        if (!timedOut && cls != 3) begin
          Run    = runAfter;
          goesT0 = runAfter && !stopped;
          if (expCount < MAXCNT) expCount++;
        end else begin
          expFault = 1'b1;
          Run      = 1'b1;
        end
      end
    end
  endtask

  task automatic runOne(input string tag, input logic [31:0] ir, input int zeros,
                        input int stopPhase, input bit runAfter);
    bit g;
    applyStimulus(ir, zeros, stopPhase, runAfter, -1, g);
    if (!g) checkIdle(tag);
  endtask

  initial begin
    bit g;
    Clear     = 1'b0;
    Run       = 1'b0;
    Stop      = 1'b0;
    Mem_Ready = 1'b0;
    IR        = 32'b0;
    expFault  = 1'b0;
    expCount  = 0;

    resetDut();
    $display("[TB] directed cases");
    runOne("neg_r5_r2", 32'h82900000, 0, -1, 1'b0);
    runOne("mul_wrap", 32'h77A20000, 0, -1, 1'b1);
    runOne("add_wait3", mkIr(5'h00, 1, 2, 3), 3, -1, 1'b1);
    runOne("div_r15", mkIr(5'h0F, 15, 7, 9), 0, -1, 1'b1);
    runOne("mem_timeout", mkIr(5'h01, 4, 5, 6), TIMEOUT, -1, 1'b1);
    runOne("illegal_1f", mkIr(5'h1F, 6, 7, 8), 0, -1, 1'b1);
    runOne("stop_in_t3", mkIr(5'h00, 9, 10, 11), 0, 3, 1'b1);
    runOne("not_r0", mkIr(5'h11, 0, 3, 12), 1, -1, 1'b0);

    applyStimulus(mkIr(5'h02, 3, 4, 5), 0, -1, 1'b1, 4, g);
    resetDut();

    $display("[TB] randomized cases");
    for (int n = 0; n < 40; n++) begin
      logic [4:0] op;
      int zeros;
      int stopPhase;
      if ($urandom_range(0, 9) < 8) op = 5'($urandom_range(0, 17));
      else                          op = 5'($urandom_range(18, 31));
      zeros     = ($urandom_range(0, 9) == 0) ? TIMEOUT + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, 3));
      stopPhase = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 6)) : -1;
      runOne($sformatf("rand%0d", n),
             mkIr(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15))),
             zeros, stopPhase, 1'($urandom_range(0, 1)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
